// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a run of consecutive words from a single-port BRAM
// and presents them as a valid/ready stream with a 2-entry registered buffer.
module bram_stream_reader #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   i_clk,
    input  logic                   i_areset_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ADDR_WIDTH-1:0]  o_bram_addr,
    output logic                   o_bram_write,
    output logic [DATA_WIDTH-1:0]  o_bram_wdata,
    input  logic [DATA_WIDTH-1:0]  i_bram_rdata,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_last,
    input  logic                   i_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [COUNT_WIDTH-1:0] issue_left;
    logic [COUNT_WIDTH-1:0] issue_left_nx;
    logic [ADDR_WIDTH-1:0]  addr_nx;
    logic                   busy_nx;
    logic                   done_nx;
    logic                   inflight;
    logic                   inflight_last;
    logic                   issue_c;
    logic                   pop_c;
    logic                   push_c;
    logic [2:0]             pending_c;

    // Second (skid) buffer entry behind the head held in o_data/o_last.
    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_data;
    logic                   skid_last;

    // The BRAM is only ever read by this block.
    assign o_bram_write = 1'b0;
    assign o_bram_wdata = '0;

    // Handshake and buffer-load bookkeeping for this cycle.
    assign pop_c     = o_valid & i_ready;
    assign push_c    = inflight;
    assign pending_c = 3'(o_valid) + 3'(skid_valid) + 3'(inflight) - 3'(pop_c);

    // Next-state, read-issue and control-output decode.
    always_comb begin
        state_nx      = state;
        issue_left_nx = issue_left;
        addr_nx       = o_bram_addr;
        busy_nx       = o_busy;
        done_nx       = 1'b0;
        issue_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        state_nx      = ST_ISSUE;
                        busy_nx       = 1'b1;
                        issue_left_nx = i_count;
                        addr_nx       = i_base;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // o_bram_addr already holds the next address; issuing reads it now.
                if (pending_c < 3'd2) begin
                    issue_c       = 1'b1;
                    issue_left_nx = issue_left - COUNT_WIDTH'(1);
                    if (issue_left == COUNT_WIDTH'(1)) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        addr_nx = o_bram_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pending_c == 3'd0) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // FSM state, address and in-flight read tracking.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state         <= ST_IDLE;
            issue_left    <= '0;
            o_bram_addr   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            issue_left    <= issue_left_nx;
            o_bram_addr   <= addr_nx;
            o_busy        <= busy_nx;
            o_done        <= done_nx;
            inflight      <= issue_c;
            inflight_last <= issue_c && (issue_left == COUNT_WIDTH'(1));
        end
    end

    // Two-entry shift buffer: head drives the stream, skid absorbs one more word.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (pop_c) begin
            if (skid_valid) begin
                o_data <= skid_data;
                o_last <= skid_last;
                if (push_c) begin
                    skid_data <= i_bram_rdata;
                    skid_last <= inflight_last;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (push_c) begin
                o_data <= i_bram_rdata;
                o_last <= inflight_last;
            end else begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end else if (push_c) begin
            if (!o_valid) begin
                o_valid <= 1'b1;
                o_data  <= i_bram_rdata;
                o_last  <= inflight_last;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= i_bram_rdata;
                skid_last  <= inflight_last;
            end
        end
    end

    // The issue rule guarantees a free slot for every returning word.
    always @(posedge i_clk) begin
        if (i_areset_n) begin
            assert (!(push_c && o_valid && skid_valid && !pop_c));
        end
    end

endmodule
